// File: rtl/sdram_refresh_scheduler.sv
// SDRAM auto-refresh scheduler: counts refresh intervals, tracks owed refreshes,
// issues them opportunistically on a quiet bus and forces a drain (holding the
// arbiter) once the debt reaches URGENT_LEVEL. All outputs are registered.
// Ports: clock/reset_n (async active-low); enable, ctrl_idle, arb_pending,
//   refresh_ack, refresh_done in; refresh_req, hold_masters, owed, overflow out.
// Optional: define SDRAM_REFRESH_STATS_EN to add refresh_count / urgent_count.
module sdram_refresh_scheduler #(
  parameter int unsigned REFI_CYCLES  = 390,
  parameter int unsigned MAX_OWED     = 8,
  parameter int unsigned URGENT_LEVEL = 6
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          ctrl_idle,
  input  logic                          arb_pending,
  output logic                          refresh_req,
  input  logic                          refresh_ack,
  input  logic                          refresh_done,
  output logic                          hold_masters,
  output logic [$clog2(MAX_OWED+1)-1:0] owed,
  output logic                          overflow
`ifdef SDRAM_REFRESH_STATS_EN
  ,
  output logic [31:0]                   refresh_count,
  output logic [15:0]                   urgent_count
`endif
);

  localparam int unsigned OW = $clog2(MAX_OWED + 1);
  localparam int unsigned CW = $clog2(REFI_CYCLES);
  localparam logic [CW-1:0] CNT_RELOAD  = CW'(REFI_CYCLES - 1);
  localparam logic [OW-1:0] OWED_MAX    = OW'(MAX_OWED);
  localparam logic [OW-1:0] OWED_URGENT = OW'(URGENT_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_URGENT,
    ST_REQ,
    ST_WAIT_DONE
  } state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [OW-1:0] owed_q, owed_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic          drain_q, drain_d;
  logic          refresh_req_q, refresh_req_d;
  logic          more_drain;

  // Interval counter; the tick is registered so owed moves one edge later.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q == '0) begin
      cnt_d  = CNT_RELOAD;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Owed counter. A tick and an ack together cancel, so a tick at saturation
  // only loses a refresh (and flags overflow) when no ack accompanies it.
  always_comb begin
    owed_d     = owed_q;
    overflow_d = overflow_q;
    if (!enable) begin
      owed_d = '0;
    end else if (tick_q && !refresh_ack) begin
      if (owed_q == OWED_MAX) overflow_d = 1'b1;
      else                    owed_d     = owed_q + 1'b1;
    end else if (refresh_ack && !tick_q && (owed_q != '0)) begin
      owed_d = owed_q - 1'b1;
    end
  end

  // Post-update owed decides whether a forced drain continues, so an ack
  // arriving together with done is already accounted for.
  assign more_drain = drain_q && (owed_d != '0);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (owed_q >= OWED_URGENT)) begin
          state_d = ST_URGENT;
          drain_d = 1'b1;
        end else if (enable && (owed_q != '0) && ctrl_idle && !arb_pending) begin
          state_d = ST_REQ;
        end
      end
      ST_URGENT: begin
        // Disabling abandons a drain that has not yet issued a request.
        if (!enable) begin
          state_d = ST_IDLE;
          drain_d = 1'b0;
        end else if (ctrl_idle) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (refresh_ack) begin
          if (!refresh_done) begin
            state_d = ST_WAIT_DONE;
          end else if (more_drain) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
            drain_d = 1'b0;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (refresh_done) begin
          if (more_drain) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
            drain_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = 1'b0;
      end
    endcase
    refresh_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= CNT_RELOAD;
      tick_q        <= 1'b0;
      owed_q        <= '0;
      overflow_q    <= 1'b0;
      state_q       <= ST_IDLE;
      drain_q       <= 1'b0;
      refresh_req_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      owed_q        <= owed_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      drain_q       <= drain_d;
      refresh_req_q <= refresh_req_d;
    end
  end

  assign refresh_req  = refresh_req_q;
  assign hold_masters = drain_q;
  assign owed         = owed_q;
  assign overflow     = overflow_q;

`ifdef SDRAM_REFRESH_STATS_EN
  logic [31:0] refresh_count_q, refresh_count_d;
  logic [15:0] urgent_count_q, urgent_count_d;

  always_comb begin
    refresh_count_d = refresh_count_q;
    urgent_count_d  = urgent_count_q;
    if (refresh_ack) refresh_count_d = refresh_count_q + 32'd1;
    if ((state_q == ST_IDLE) && (state_d == ST_URGENT)) urgent_count_d = urgent_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      refresh_count_q <= '0;
      urgent_count_q  <= '0;
    end else begin
      refresh_count_q <= refresh_count_d;
      urgent_count_q  <= urgent_count_d;
    end
  end

  assign refresh_count = refresh_count_q;
  assign urgent_count  = urgent_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
